// File: rtl/mux_n_1_pipe.sv
// N-to-1 valid/ready multiplexer (explicit select or round-robin) feeding a 2-entry output skid buffer.
// Optional MUX_PIPE_PARITY_EN adds out_parity: even parity of the head entry, stored per entry at push.
module mux_n_1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_PIPE_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  localparam logic [SEL_W:0]   LP_NUM_IN = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LP_RR_RST = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] w_in_arr [NUM_IN];
  logic             w_sel_valid;
  logic             w_rr_valid;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_grant_valid;
  logic [SEL_W-1:0] w_grant_idx;
  logic             w_push;
  logic             w_pop;

  logic [WIDTH-1:0] r_data [2];
  logic [SEL_W-1:0] r_sel  [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic [SEL_W-1:0] r_rr_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign w_in_arr[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    w_sel_valid = 1'b0;
    if ({1'b0, sel} < LP_NUM_IN) begin
      w_sel_valid = in_valid[sel];
    end
  end

  // Walk offsets from farthest to nearest so the first valid input after rr_ptr wins.
  always_comb begin : p_rr_scan
    logic [SEL_W-1:0] v_scan;
    w_rr_valid = 1'b0;
    w_rr_idx   = '0;
    v_scan     = '0;
    for (int k = NUM_IN; k >= 1; k--) begin
      v_scan = SEL_W'((int'(r_rr_ptr) + k) % NUM_IN);
      if (in_valid[v_scan]) begin
        w_rr_valid = 1'b1;
        w_rr_idx   = v_scan;
      end
    end
  end

  assign w_grant_valid = mode ? w_rr_valid : w_sel_valid;
  assign w_grant_idx   = mode ? w_rr_idx   : sel;

  // Ready looks only at the registered count, never at out_ready.
  assign w_push = rst_n && w_grant_valid && (r_count != 2'd2);
  assign w_pop  = (r_count != 2'd0) && out_ready;

  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = w_push && (w_grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_sel[0]  <= '0;
      r_sel[1]  <= '0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_count   <= 2'd0;
      r_rr_ptr  <= LP_RR_RST;
    end else begin
      if (w_push) begin
        r_data[r_tail] <= w_in_arr[w_grant_idx];
        r_sel[r_tail]  <= w_grant_idx;
        r_tail         <= ~r_tail;
        r_rr_ptr       <= w_grant_idx;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data  = r_data[r_head];
  assign out_sel   = r_sel[r_head];
  assign out_valid = (r_count != 2'd0);

`ifdef MUX_PIPE_PARITY_EN
  logic r_par [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par[0] <= 1'b0;
      r_par[1] <= 1'b0;
    end else if (w_push) begin
      r_par[r_tail] <= ^w_in_arr[w_grant_idx];
    end
  end

  assign out_parity = r_par[r_head];
`endif

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Randomised scoreboard bench for mux_n_1_pipe: a reference process predicts grants/readiness and
// queues expected outputs; an independent monitor checks every presented head entry in FIFO order.
module tb_mux_n_1_pipe;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [1:0]     sel;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;
`ifdef MUX_PIPE_PARITY_EN
  logic           out_parity;
`endif

  mux_n_1_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_total  = 0;
  int   n_pass   = 0;
  bit   in_reset = 1'b1;
  int   m_cnt    = 0;
  int   m_rr     = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  // Reference rule: explicit select, or first valid input strictly after the last winner.
  function automatic int ref_grant(input bit md, input int s, input logic [N-1:0] v, input int rr);
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int off = 1; off <= N; off++) begin
      if (v[(rr + off) % N]) return (rr + off) % N;
    end
    return -1;
  endfunction

  // Reference process: runs after the monitor in each cycle.
  always @(negedge clk) begin
    #1;
    if (rst_n && !in_reset) begin
      int           g;
      logic [N-1:0] er;
      int           cnt_before;
      g          = ref_grant(mode, int'(sel), in_valid, m_rr);
      er         = '0;
      cnt_before = m_cnt;
      if (g >= 0 && m_cnt < 2) er[g] = 1'b1;
      check("in_ready", 32'(in_ready), 32'(er));
      check("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      if (er != '0) begin
        exp_t e;
        e.data = in_data[g*W +: W];
        e.idx  = 2'(g);
        exp_q.push_back(e);
        m_rr = g;
        m_cnt++;
      end
      if (cnt_before != 0 && out_ready) m_cnt--;
    end
  end

  // Monitor: whatever the DUT presents must equal the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && !in_reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got data %h sel %0d, expected nothing queued", out_data, out_sel);
      end else begin
        check("out_data", out_data, exp_q[0].data);
        check("out_sel", 32'(out_sel), 32'(exp_q[0].idx));
`ifdef MUX_PIPE_PARITY_EN
        check("out_parity", 32'(out_parity), 32'(^exp_q[0].data));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit md, input logic [1:0] s, input logic [N-1:0] v, input bit ordy);
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, away from both clock edges.
  task automatic do_reset();
    @(posedge clk);
    #2;
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_state();
    exp_q.delete();
    m_cnt = 0;
    m_rr  = N - 1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst_n    = 1'b1;
    in_reset = 1'b0;

    // Explicit select of input 2 with a known word, then idle.
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    in_data[2*W +: W] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    drive(1'b0, 2'd2, 4'b0000, 1'b1);

    // Select points at an idle input: nothing accepted.
    drive(1'b0, 2'd1, 4'b0100, 1'b1);
    drive(1'b0, 2'd1, 4'b0100, 1'b1);

    // Round-robin from a fresh reset with every input valid.
    do_reset();
    for (int c = 0; c < 9; c++) drive(1'b1, 2'd0, 4'b1111, 1'b1);

    // Fill while stalled, then drain; push/pop overlap with one entry buffered.
    for (int c = 0; c < 3; c++) drive(1'b0, 2'd0, 4'b0001, 1'b0);
    for (int c = 0; c < 4; c++) drive(1'b0, 2'd0, 4'b0001, 1'b1);
    drive(1'b0, 2'd0, 4'b0000, 1'b1);

    // Randomised traffic, including out-of-range-free explicit selects and stalls.
    for (int c = 0; c < 500; c++)
      drive(1'(($urandom) & 1), 2'($urandom_range(0, 3)), 4'($urandom), $urandom_range(0, 3) != 0);

    // Reset with the buffer full discards everything.
    for (int c = 0; c < 3; c++) drive(1'b0, 2'd3, 4'b1000, 1'b0);
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    in_data   = '0;
    in_data[W-1:0] = 32'h0000_0007;
    @(posedge clk);
    #1;
    drive(1'b1, 2'd0, 4'b0000, 1'b1);

    // Drain with a bounded wait.
    begin
      int budget = 20;
      in_valid  = '0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        #1;
        budget--;
      end
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
